// File: rtl/ball_collision_detector.sv
// Per-frame ball/rope and ball/player overlap detector with post-hit invulnerability.
// Optional saturating hit counters are built when BALL_HIT_COUNTER_EN is defined.
//
// state      | meaning
// WAIT_FRAME | after reset, requests ignored until the first startOfFrame
// SCAN       | rope detection open, accumulating overlaps for this frame
// LOCKED     | a rope hit is latched, later rope overlaps are discarded
// REPORT     | one-cycle result pulse for the previous frame
module ball_collision_detector #(
    parameter int NUM_BALLS     = 15,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS-1:0] ballRequests,
    input  logic                 ropeRequest,
    input  logic                 playerRequest,
    output logic [NUM_BALLS-1:0] ballHitRope,
    output logic                 ropeHit,
    output logic                 playerHit,
`ifdef BALL_HIT_COUNTER_EN
    output logic [7:0]           ropeHitCount,
    output logic [3:0]           playerHitCount,
`endif
    output logic                 invulnerable
);

    localparam int CNT_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SCAN       = 2'd1,
        LOCKED     = 2'd2,
        REPORT     = 2'd3
    } state_t;

    state_t               state, nextState;
    logic [NUM_BALLS-1:0] ropeHitReg, ropeHitNext, lowestBall;
    logic                 playerAcc, playerAccNext;
    logic [CNT_W-1:0]     invulnCnt, invulnCntNext;
    logic                 anyBall, frameLive, frameEnd, ropeOpen, ropeLatch;

    always_comb begin
        anyBall    = |ballRequests;
        lowestBall = ballRequests & (~ballRequests + NUM_BALLS'(1));
        frameLive  = (state != WAIT_FRAME) || startOfFrame;
        frameEnd   = startOfFrame && (state != WAIT_FRAME);
        // The startOfFrame pixel sees the cleared accumulator, so the lock reopens then.
        ropeOpen   = frameLive && (frameEnd || (ropeHitReg == '0));
        ropeLatch  = ropeOpen && ropeRequest && anyBall;

        ropeHitNext = ropeHitReg;
        if (ropeLatch)
            ropeHitNext = lowestBall;
        else if (frameEnd)
            ropeHitNext = '0;

        playerAccNext = frameEnd ? 1'b0 : playerAcc;
        if (frameLive && playerRequest && anyBall)
            playerAccNext = 1'b1;

        invulnCntNext = invulnCnt;
        if (playerHit)
            invulnCntNext = CNT_W'(INVULN_FRAMES);
        else if (startOfFrame && (invulnCnt != '0))
            invulnCntNext = invulnCnt - CNT_W'(1);
    end

    always_comb begin
        nextState = state;
        case (state)
            WAIT_FRAME: if (startOfFrame) nextState = (ropeHitNext != '0) ? LOCKED : SCAN;
            SCAN:       if (startOfFrame) nextState = REPORT;
                        else if (ropeLatch) nextState = LOCKED;
            LOCKED:     if (startOfFrame) nextState = REPORT;
            REPORT:     if (startOfFrame) nextState = REPORT;
                        else nextState = (ropeHitNext != '0) ? LOCKED : SCAN;
            default:    nextState = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= WAIT_FRAME;
            ropeHitReg   <= '0;
            playerAcc    <= 1'b0;
            invulnCnt    <= '0;
            ballHitRope  <= '0;
            ropeHit      <= 1'b0;
            playerHit    <= 1'b0;
            invulnerable <= 1'b0;
        end else begin
            state        <= nextState;
            ropeHitReg   <= ropeHitNext;
            playerAcc    <= playerAccNext;
            invulnCnt    <= invulnCntNext;
            // Suppression uses the count as it stood before this frame's decrement.
            ballHitRope  <= frameEnd ? ropeHitReg : '0;
            ropeHit      <= frameEnd && (ropeHitReg != '0);
            playerHit    <= frameEnd && playerAcc && (invulnCnt == '0);
            invulnerable <= (invulnCntNext != '0);
        end
    end

`ifdef BALL_HIT_COUNTER_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ropeHitCount   <= '0;
            playerHitCount <= '0;
        end else begin
            if (ropeHit && (ropeHitCount != 8'hFF))
                ropeHitCount <= ropeHitCount + 8'd1;
            if (playerHit && (playerHitCount != 4'hF))
                playerHitCount <= playerHitCount + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ball_collision_detector.sv
// Directed bench for ball_collision_detector with INVULN_FRAMES=3.
// Counter checks are compiled in when BALL_HIT_COUNTER_EN is defined.
module tb_ball_collision_detector;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [14:0] ballRequests = '0;
    logic        ropeRequest = 1'b0;
    logic        playerRequest = 1'b0;
    logic [14:0] ballHitRope;
    logic        ropeHit, playerHit, invulnerable;
`ifdef BALL_HIT_COUNTER_EN
    logic [7:0]  ropeHitCount;
    logic [3:0]  playerHitCount;
`endif

    int total = 0;
    int bad   = 0;

    ball_collision_detector #(.NUM_BALLS(15), .INVULN_FRAMES(3)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .ballRequests  (ballRequests),
        .ropeRequest   (ropeRequest),
        .playerRequest (playerRequest),
        .ballHitRope   (ballHitRope),
        .ropeHit       (ropeHit),
        .playerHit     (playerHit),
`ifdef BALL_HIT_COUNTER_EN
        .ropeHitCount  (ropeHitCount),
        .playerHitCount(playerHitCount),
`endif
        .invulnerable  (invulnerable)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [14:0] balls, input logic rope, input logic player);
        ballRequests  = balls;
        ropeRequest   = rope;
        playerRequest = player;
        step();
        ballRequests  = '0;
        ropeRequest   = 1'b0;
        playerRequest = 1'b0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    initial begin
        step();
        step();
        check_val("rst_ballHitRope", ballHitRope, 0);
        check_val("rst_ropeHit", ropeHit, 0);
        check_val("rst_playerHit", playerHit, 0);
        check_val("rst_invuln", invulnerable, 0);
        resetN = 1'b1;
        // overlap before the first frame must be ignored
        pix(15'h0001, 1'b1, 1'b1);
        step();
        sof();
        check_val("first_sof_rope", ropeHit, 0);
        check_val("first_sof_player", playerHit, 0);

        // lowest set index wins
        pix(15'h0000, 1'b1, 1'b0);
        pix(15'h0006, 1'b1, 1'b0);
        step();
        sof();
        check_val("basic_ballHitRope", ballHitRope, 15'h0002);
        check_val("basic_ropeHit", ropeHit, 1);
        check_val("basic_player", playerHit, 0);
        step();
        check_val("basic_pulse_end", ballHitRope, 0);
        check_val("basic_ropeHit_end", ropeHit, 0);

        // lock: later lower-index hit discarded
        pix(15'h0020, 1'b1, 1'b0);
        pix(15'h0001, 1'b1, 1'b0);
        sof();
        check_val("locked_ballHitRope", ballHitRope, 15'h0020);
        step();
        pix(15'h5010, 1'b1, 1'b0);
        sof();
        check_val("multi_ballHitRope", ballHitRope, 15'h0010);
        step();
        pix(15'h0008, 1'b0, 1'b0);
        pix(15'h0000, 1'b1, 1'b0);
        sof();
        check_val("empty_ballHitRope", ballHitRope, 0);
        check_val("empty_ropeHit", ropeHit, 0);

        // overlap in the SOF cycle belongs to the new frame
        step();
        ballRequests = 15'h0004;
        ropeRequest  = 1'b1;
        sof();
        ballRequests = '0;
        ropeRequest  = 1'b0;
        check_val("sofpix_not_now", ropeHit, 0);
        pix(15'h0001, 1'b1, 1'b0);
        sof();
        check_val("sofpix_next", ballHitRope, 15'h0004);

        // back-to-back SOF
        step();
        pix(15'h0008, 1'b1, 1'b0);
        startOfFrame = 1'b1;
        step();
        check_val("b2b_first", ballHitRope, 15'h0008);
        step();
        startOfFrame = 1'b0;
        check_val("b2b_second", ballHitRope, 0);
        check_val("b2b_second_rope", ropeHit, 0);
        step();
        check_val("b2b_after", ropeHit, 0);

        // invulnerability window
        pix(15'h0008, 1'b0, 1'b1);
        sof();
        check_val("inv_hit", playerHit, 1);
        check_val("inv_rope_indep", ropeHit, 0);
        step();
        check_val("inv_hit_end", playerHit, 0);
        check_val("inv_on", invulnerable, 1);
        for (int k = 1; k <= 3; k++) begin
            pix(15'h0008, 1'b0, 1'b1);
            sof();
            check_val($sformatf("inv_suppr_%0d", k), playerHit, 0);
            step();
            check_val($sformatf("inv_flag_%0d", k), invulnerable, (k != 3));
        end
        pix(15'h0008, 1'b0, 1'b1);
        sof();
        check_val("inv_rehit", playerHit, 1);
        step();
        check_val("inv_rearmed", invulnerable, 1);

        // asynchronous reset mid-frame
        pix(15'h0002, 1'b1, 1'b1);
        resetN = 1'b0;
        #2;
        check_val("midrst_invuln", invulnerable, 0);
        check_val("midrst_ballHitRope", ballHitRope, 0);
        step();
        resetN = 1'b1;
        step();
        sof();
        check_val("midrst_first_sof", ropeHit, 0);
        check_val("midrst_first_sof_pl", playerHit, 0);
        step();
        sof();
        check_val("midrst_empty", ballHitRope, 0);

`ifdef BALL_HIT_COUNTER_EN
        step();
        check_val("cnt_rst_rope", ropeHitCount, 0);
        check_val("cnt_rst_player", playerHitCount, 0);
        for (int f = 0; f < 300; f++) begin
            pix(15'h0001, 1'b1, 1'b0);
            sof();
            step();
            if (f == 9) check_val("cnt_10", ropeHitCount, 10);
        end
        check_val("cnt_sat", ropeHitCount, 255);
        step();
        check_val("cnt_sat_hold", ropeHitCount, 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_collision_detector.md
Name: ball_collision_detector

Overview:
- Sits directly downstream of the ball priority mux, alongside the top-level object mux.
- Consumes the per-ball draw requests together with the rope (shot) and player draw requests for the same pixel.
- Accumulates pixel overlaps across one video frame and reports them once per frame as single-cycle pulses.
- Game logic uses these pulses for ball split / rope retract (ballHitRope) and life loss (playerHit).

Parameters:
- NUM_BALLS, 15, number of ball request lines; index 0 has highest hit priority (small ball 1 first, huge ball last).
- INVULN_FRAMES, 60, frames after a reported player hit during which further player hits are suppressed.

Ports:
- clk  input  1  system pixel clock.
- resetN  input  1  asynchronous active-low reset.
- startOfFrame  input  1  one-cycle pulse at frame start, synchronous to clk.
- ballRequests  input  NUM_BALLS  per-ball draw requests for the current pixel.
- ropeRequest  input  1  rope draw request for the current pixel.
- playerRequest  input  1  player draw request for the current pixel.
- ballHitRope  output  NUM_BALLS  one-hot, one-cycle pulse: the ball that hit the rope last frame.
- ropeHit  output  1  one-cycle pulse, equals OR of ballHitRope.
- playerHit  output  1  one-cycle pulse: a ball overlapped the player last frame (not suppressed).
- invulnerable  output  1  high while the invulnerability counter is non-zero.

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous, active-low. All outputs and state are 0 / WAIT_FRAME on reset.
- State machine:
  - WAIT_FRAME: ignore requests until the first startOfFrame, then go to SCAN.
  - SCAN: on any cycle where ropeRequest and at least one ballRequests bit are high, latch the one-hot lowest set index into ropeHitReg and go to LOCKED.
  - LOCKED: rope detection is closed for the rest of the frame. Later or simultaneous higher-index overlaps are discarded.
  - REPORT: entered from SCAN or LOCKED on startOfFrame. Lasts exactly one cycle, then returns to SCAN.
- Player detection: playerAcc is set on any cycle with playerRequest and any ballRequests bit high, in SCAN or LOCKED. It is independent of the rope lock.
- REPORT cycle outputs (the cycle after startOfFrame is sampled):
  - ballHitRope = ropeHitReg; ropeHit = |ropeHitReg.
  - playerHit = playerAcc && invulnCnt == 0.
  - If playerHit asserts, invulnCnt loads INVULN_FRAMES.
  - Accumulators clear in the same cycle. Outputs return to 0 the following cycle.
- Pixel in the startOfFrame cycle: belongs to the new frame and is evaluated against the freshly cleared accumulators. Accumulator clear has priority over the previous frame's set, then that pixel may set the new accumulator.
- Pixel in the REPORT cycle: evaluated as SCAN for the new frame. A rope overlap there latches and moves to LOCKED directly after REPORT.
- invulnCnt:
  - Width is clog2(INVULN_FRAMES+1).
  - Decrements by 1 on each startOfFrame while non-zero; saturates at 0, no wrap.
  - Reload and decrement never coincide, because reload happens in REPORT, one cycle after startOfFrame.
  - invulnerable = (invulnCnt != 0), registered.
- Frame with no overlaps: REPORT produces all-zero outputs.
- Reset mid-frame: partial accumulations are discarded; the block returns to WAIT_FRAME with no pulse.
- Back-to-back startOfFrame on consecutive cycles: the second pulse triggers a REPORT of an empty frame (zeros). No pulse is lost or duplicated.
- Latency: a hit anywhere in frame N is reported exactly once, one cycle after the startOfFrame that begins frame N+1.

Optional Feature:
- Macro: BALL_HIT_COUNTER_EN.
- When defined:
  - Adds output ropeHitCount [7:0]. It increments by 1 in every REPORT cycle with ropeHit=1 and saturates at 255.
  - Adds output playerHitCount [3:0], saturating at 15.
  - Both counters reset to 0.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset, then SOF. In frame 1, ropeRequest=1 with ballRequests=15'h0006 at one pixel. Next SOF -> ballHitRope=15'h0002, ropeHit=1 for exactly 1 cycle.
- Frame with rope overlaps on ball 5, then later on ball 0 -> only ballHitRope=15'h0020 reported (LOCKED ignores the later hit).
- Player overlaps ball 3 in frame 1 with INVULN_FRAMES=3 -> playerHit pulse, invulnerable=1. Overlaps in the next 3 frames report playerHit=0. invulnerable drops after the 3rd subsequent SOF; the overlap in frame 5 pulses playerHit again.
- Overlap asserted in the same cycle as SOF -> not reported at that SOF; reported at the following SOF.
- Assert resetN=0 mid-frame after a rope overlap -> all outputs 0; the first SOF after release produces no pulse.
- With BALL_HIT_COUNTER_EN: 300 frames each with a rope hit -> ropeHitCount saturates at 255 and stays there.
